alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu_arb_alu.sv | 31 +++
 rtl/alu_arb.sv | 104 ++++++++++
 tb/tb_alu_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op codes and slot states.
package alu_arb_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_arb_alu.sv
// Combinational ALU shared by both requesters; undefined op codes yield zero.
module alu_arb_alu
   import alu_arb_pkg::*;
#(
   parameter int DATAW = 32
) (
   input  logic [3:0]       sel,
   input  logic [DATAW-1:0] a,
   input  logic [DATAW-1:0] b,
   output logic [DATAW-1:0] y
);

   always_comb begin
      // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
      y = '0;
      case (sel)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SLT:  y = {{(DATAW-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(DATAW-1){1'b0}}, (a < b)};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = DATAW'($signed(a) >>> b[4:0]);
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Two requesters share one ALU through a round-robin grant and a one-entry result slot
// that can be drained and refilled in the same cycle.
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int DATAW = 32,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_sel,
   input  logic [DATAW-1:0] req0_a,
   input  logic [DATAW-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [DATAW-1:0] rsp0_out,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_sel,
   input  logic [DATAW-1:0] req1_a,
   input  logic [DATAW-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [DATAW-1:0] rsp1_out,
   output logic [CNTW-1:0]  conflict_cnt
);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [DATAW-1:0] result_q, result_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic             drain, slot_free, grant, accept;
   logic [3:0]       alu_sel;
   logic [DATAW-1:0] alu_a, alu_b, alu_y;

   always_comb begin
      drain     = (state_q == ST_FULL) && (owner_q ? rsp1_ready : rsp0_ready);
      slot_free = (state_q == ST_EMPTY) || drain;
      // On a tie the requester not accepted most recently wins.
      grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
      req0_ready = ~rst & slot_free & ~grant;
      req1_ready = ~rst & slot_free & grant;
      accept     = grant ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
      alu_sel    = grant ? req1_sel : req0_sel;
      alu_a      = grant ? req1_a   : req0_a;
      alu_b      = grant ? req1_b   : req0_b;
   end

   alu_arb_alu #(.DATAW(DATAW)) u_alu (
      .sel (alu_sel),
      .a   (alu_a),
      .b   (alu_b),
      .y   (alu_y)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      if (accept) begin
         state_d  = ST_FULL;
         owner_d  = grant;
         last_d   = grant;
         result_d = alu_y;
      end else if (drain) begin
         state_d  = ST_EMPTY;
         result_d = '0;
      end
      // Only one request can be accepted per cycle, so both valid always means contention.
      if (req0_valid && req1_valid && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q  <= ST_EMPTY;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rsp0_valid   = ~rst & (state_q == ST_FULL) & ~owner_q;
   assign rsp1_valid   = ~rst & (state_q == ST_FULL) & owner_q;
   assign rsp0_out     = rsp0_valid ? result_q : '0;
   assign rsp1_out     = rsp1_valid ? result_q : '0;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_alu_arb;
   import alu_arb_pkg::*;

   localparam int DATAW = 32;
   localparam int CNTW  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [3:0]       req0_sel = '0, req1_sel = '0;
   logic [DATAW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic             rsp0_valid, rsp1_valid;
   logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [DATAW-1:0] rsp0_out, rsp1_out;
   logic [CNTW-1:0]  conflict_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arb #(.DATAW(DATAW), .CNTW(CNTW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_sel     (req0_sel),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .rsp0_valid   (rsp0_valid),
      .rsp0_ready   (rsp0_ready),
      .rsp0_out     (rsp0_out),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_sel     (req1_sel),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .rsp1_valid   (rsp1_valid),
      .rsp1_ready   (rsp1_ready),
      .rsp1_out     (rsp1_out),
      .conflict_cnt (conflict_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
      case (s)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'd0;
      endcase
   endfunction

   // Model: at most one pending response, who won last, and the contention count.
   typedef struct {
      bit          owner;
      logic [31:0] val;
   } held_t;

   held_t held[$];
   bit    m_last = 1'b1;
   int    m_cnt  = 0;

   // Inputs only change just after a rising edge, so at the falling edge they are the
   // values the next rising edge will sample.
   always @(negedge clk) begin
      bit          free, win, e_r0, e_r1, e_v0, e_v1, acc;
      logic [31:0] e_o0, e_o1, wv;
      free = 1'b1;
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      e_o0 = '0;
      e_o1 = '0;
      if (held.size() != 0) begin
         free = held[0].owner ? rsp1_ready : rsp0_ready;
         e_v0 = !rst && !held[0].owner;
         e_v1 = !rst && held[0].owner;
         e_o0 = e_v0 ? held[0].val : '0;
         e_o1 = e_v1 ? held[0].val : '0;
      end
      if (req0_valid && req1_valid) win = ~m_last;
      else                          win = req1_valid;
      e_r0 = !rst && free && !win;
      e_r1 = !rst && free && win;

      check("cmp_req0_ready", 64'(req0_ready), 64'(e_r0));
      check("cmp_req1_ready", 64'(req1_ready), 64'(e_r1));
      check("cmp_rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
      check("cmp_rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
      check("cmp_rsp0_out",   64'(rsp0_out),   64'(e_o0));
      check("cmp_rsp1_out",   64'(rsp1_out),   64'(e_o1));
      check("cmp_conflict",   64'(conflict_cnt), 64'(m_cnt));

      if (rst) begin
         held.delete();
         m_last = 1'b1;
         m_cnt  = 0;
      end else begin
         acc = win ? (req1_valid && e_r1) : (req0_valid && e_r0);
         wv  = win ? ref_alu(req1_sel, req1_a, req1_b) : ref_alu(req0_sel, req0_a, req0_b);
         if (held.size() != 0 && free) void'(held.pop_front());
         if (acc) begin
            held.push_back('{owner: win, val: wv});
            m_last = win;
         end
         if (req0_valid && req1_valid && m_cnt < (2**CNTW - 1)) m_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] b);
      req0_valid = v;
      req0_sel   = s;
      req0_a     = a;
      req0_b     = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] b);
      req1_valid = v;
      req1_sel   = s;
      req1_a     = a;
      req1_b     = b;
   endtask

   task automatic pulse_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset with a request pending: nothing may be accepted.
      drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
      probe();
      check("rst_req0_ready", 64'(req0_ready), 64'd0);
      check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      tick();
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      rst = 1'b0;
      probe();
      check("rst_conflict", 64'(conflict_cnt), 64'd0);

      // Single ADD from requester 0.
      tick();
      rsp0_ready = 1'b1;
      drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
      probe();
      check("add_req0_ready", 64'(req0_ready), 64'd1);
      check("add_req1_ready", 64'(req1_ready), 64'd0);
      tick();
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      probe();
      check("add_rsp0_valid", 64'(rsp0_valid), 64'd1);
      check("add_rsp0_out",   64'(rsp0_out),   64'd12);
      check("add_rsp1_valid", 64'(rsp1_valid), 64'd0);

      // Both requesters contend every cycle: accept order alternates 0,1,0,1.
      pulse_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive0(1'b1, ALU_SUB, 32'd3, 32'd5);
      drive1(1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
      for (int i = 0; i < 4; i++) begin
         probe();
         check("rr_req0_ready", 64'(req0_ready), 64'(i % 2 == 0));
         check("rr_req1_ready", 64'(req1_ready), 64'(i % 2 == 1));
         check("rr_conflict",   64'(conflict_cnt), 64'(i));
         if (i % 2 == 1) check("rr_rsp0_out", 64'(rsp0_out), 64'hFFFF_FFFE);
         if (i == 2)     check("rr_rsp1_out", 64'(rsp1_out), 64'hF800_0000);
         tick();
      end
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
      probe();
      check("rr_rsp1_last", 64'(rsp1_out), 64'hF800_0000);

      // Held SLTU result with back-pressure, then same-cycle drain and refill.
      tick();
      rsp1_ready = 1'b0;
      drive1(1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
      tick();
      drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
      drive1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
      for (int i = 0; i < 3; i++) begin
         probe();
         check("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
         check("bp_rsp1_out",   64'(rsp1_out),   64'd1);
         check("bp_req0_ready", 64'(req0_ready), 64'd0);
         check("bp_req1_ready", 64'(req1_ready), 64'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      probe();
      check("bp_refill_req0", 64'(req0_ready), 64'd1);
      tick();
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
      probe();
      check("bp_refill_out", 64'(rsp0_out), 64'd2);

      // Undefined op code still handshakes, result zero.
      tick();
      drive0(1'b1, 4'b1111, 32'hDEAD, 32'd1);
      probe();
      check("undef_req0_ready", 64'(req0_ready), 64'd1);
      tick();
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      probe();
      check("undef_rsp0_valid", 64'(rsp0_valid), 64'd1);
      check("undef_rsp0_out",   64'(rsp0_out),   64'd0);

      // Reset while FULL discards the result and restores the tie-break.
      tick();
      rsp1_ready = 1'b0;
      drive1(1'b1, ALU_ADD, 32'd40, 32'd2);
      tick();
      drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
      probe();
      check("rf_rsp1_held", 64'(rsp1_out), 64'd42);
      tick();
      rst = 1'b1;
      probe();
      check("rf_in_rst_valid", 64'(rsp1_valid), 64'd0);
      tick();
      rst = 1'b0;
      probe();
      check("rf_rsp0_valid", 64'(rsp0_valid), 64'd0);
      check("rf_rsp1_valid", 64'(rsp1_valid), 64'd0);
      check("rf_conflict",   64'(conflict_cnt), 64'd0);
      tick();
      drive0(1'b1, ALU_OR, 32'h10, 32'h01);
      drive1(1'b1, ALU_AND, 32'hFF, 32'h0F);
      probe();
      check("rf_tie_req0", 64'(req0_ready), 64'd1);
      check("rf_tie_req1", 64'(req1_ready), 64'd0);

      // Saturation: 2^CNTW+5 contention cycles.
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      for (int i = 0; i < (2**CNTW) + 5; i++) tick();
      probe();
      check("sat_conflict", 64'(conflict_cnt), 64'd15);
      tick();
      probe();
      check("sat_hold", 64'(conflict_cnt), 64'd15);

      tick();
      drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
      drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
